gray_sequencer: RTL and testbench

//  Controller that sequences a WIDTH-bit binary count through the binary-to-Gray

---
 rtl/gray_sequencer.sv | 115 +++++++++++
 tb/tb_gray_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gray_sequencer.sv
// Gray-code sequencer: walks a binary index up or down, registers its Gray mapping
// alongside it, and streams each code over a valid/ready handshake.
module gray_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic             loop,
  input  logic             stop,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic             loop_q, loop_d;
  logic             term;

  assign term = dir_q ? (bin_q == ZERO) : (bin_q == MAXV);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    loop_d  = loop_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          bin_d   = dir ? MAXV : ZERO;
          dir_d   = dir;
          loop_d  = loop;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Stop wins over everything; a coincident handshake still completed, we
        // simply issue nothing further and keep the last code visible.
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (valid_q && ready) begin
          if (!term) begin
            bin_d = dir_q ? (bin_q - 1'b1) : (bin_q + 1'b1);
          end else if (loop_q) begin
            bin_d = dir_q ? MAXV : ZERO;
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // Gray derived from the next binary so both registers update together.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      loop_q  <= loop_d;
    end
  end

  assign valid    = valid_q;
  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_gray_sequencer.sv
// Directed bench for gray_sequencer (WIDTH=4): up/down passes, backpressure,
// looping, stop, ignored inputs and asynchronous reset.
module tb_gray_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, dir, loop, stop, ready;
  logic       valid, busy, done;
  logic [3:0] bin_out, gray_out;

  int checks = 0;
  int failures = 0;
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .loop(loop),
    .stop(stop), .ready(ready), .valid(valid), .bin_out(bin_out),
    .gray_out(gray_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cnt, k, e;
    logic [3:0] prev;
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; loop = 1'b0; stop = 1'b0; ready = 1'b0;
    #1;
    chk("rst_valid", valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_bin", bin_out, 0); chk("rst_gray", gray_out, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Up pass
    start = 1'b1; dir = 1'b0; loop = 1'b0; ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("up_valid", valid, 1); chk("up_busy", busy, 1);
      chk("up_bin", bin_out, i); chk("up_gray", gray_out, gtab[i]);
      chk("up_nodone", done, 0);
      step();
    end
    chk("up_done", done, 1); chk("up_valid_off", valid, 0); chk("up_busy_off", busy, 0);
    step();
    chk("up_done_pulse", done, 0);

    // Down pass with alternating backpressure
    start = 1'b1; dir = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    cnt = 0; k = 0;
    while (cnt < 16 && k < 40) begin
      ready = (k % 2 == 0);
      e = 15 - cnt;
      chk("dn_valid", valid, 1); chk("dn_bin", bin_out, e[3:0]);
      chk("dn_gray", gray_out, gtab[e]); chk("dn_nodone", done, 0);
      step();
      if (ready) cnt++;
      k++;
    end
    chk("dn_transfers", cnt, 16);
    chk("dn_done", done, 1);
    step();
    chk("dn_done_pulse", done, 0); chk("dn_valid_off", valid, 0);

    // Continuous loop, then stop
    start = 1'b1; dir = 1'b0; loop = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("lp_bin", bin_out, i % 16); chk("lp_gray", gray_out, gtab[i % 16]);
      chk("lp_nodone", done, 0); chk("lp_valid", valid, 1);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("lp_stop_valid", valid, 0); chk("lp_stop_busy", busy, 0);
    chk("lp_stop_done", done, 0); chk("lp_stop_bin", bin_out, 8);
    step();
    chk("lp_stop_done2", done, 0);

    // Stop coinciding with a transfer at bin=5
    start = 1'b1; loop = 1'b0; ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("st_bin_pre", bin_out, 5);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("st_bin_hold", bin_out, 5); chk("st_gray_hold", gray_out, gtab[5]);
    chk("st_valid", valid, 0); chk("st_busy", busy, 0); chk("st_done", done, 0);
    step();
    chk("st_idle_bin", bin_out, 5);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("st_restart_bin", bin_out, 0); chk("st_restart_valid", valid, 1);

    // Ignored start/dir during RUN and DONE; scoreboard on Gray property
    prev = gray_out;
    for (int i = 0; i < 16; i++) begin
      start = (i == 3);
      dir = (i >= 6);
      chk("ig_bin", bin_out, i);
      chk("ig_gray_map", gray_out, bin_out ^ (bin_out >> 1));
      if (i > 0) chk("ig_onebit", $countones(prev ^ gray_out), 1);
      prev = gray_out;
      step();
    end
    chk("ig_done", done, 1);
    start = 1'b1;
    step();
    start = 1'b0; dir = 1'b0;
    chk("ig_done_start_valid", valid, 0); chk("ig_done_start_busy", busy, 0);
    chk("ig_done_pulse", done, 0);
    step();
    chk("ig_idle_valid", valid, 0);

    // Asynchronous reset mid-run
    start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("ar_pre_valid", valid, 1); chk("ar_pre_bin", bin_out, 2);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", valid, 0); chk("ar_busy", busy, 0); chk("ar_done", done, 0);
    chk("ar_bin", bin_out, 0); chk("ar_gray", gray_out, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_post_done", done, 0); chk("ar_post_valid", valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
